hamming_burst_decoder: RTL

//  Downstream stage of the 8->12 bit encoder. Accepts a burst of 12-bit Hamming(12,8) codewords,

---
 rtl/hamming_burst_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hamming_burst_decoder.sv
// Hamming(12,8) burst decoder: corrects single-bit errors, flags syndromes 13..15,
// buffers up to DEPTH decoded bytes and drains them in order over valid/ready.
module hamming_burst_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [11:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err_fix,
  output logic             out_err_bad,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       err_total
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_err_total;
  logic [9:0]       r_buf [DEPTH];

  logic [9:0] w_dec;
  logic [9:0] w_head;
  logic       w_accept;
  logic       w_pop;
  logic       w_last;

  // Result packed as {data[7:0], fix, bad}; data positions 3,5,6,7,9,10,11,12.
  function automatic logic [9:0] decode(input logic [11:0] cw);
    logic [3:0]  syn;
    logic [11:0] c;
    logic        fix;
    logic        bad;
    syn = {^(cw & 12'hF80), ^(cw & 12'h878), ^(cw & 12'h666), ^(cw & 12'h555)};
    c   = cw;
    fix = 1'b0;
    bad = 1'b0;
    if (syn == 4'd0) begin
      c = cw;
    end else if (syn <= 4'd12) begin
      c   = cw ^ (12'h001 << (syn - 4'd1));
      fix = 1'b1;
    end else begin
      bad = 1'b1;
    end
    return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2], fix, bad};
  endfunction

  assign w_dec    = decode(in_data);
  assign in_ready = (r_state != S_DRAIN) && (r_count < CNT_W'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_pop    = (r_state == S_DRAIN) && out_ready;
  assign w_last   = w_pop && (r_count == CNT_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_COLLECT;
        else          w_next = S_IDLE;
      end
      S_COLLECT: begin
        if (w_accept && (r_count == CNT_W'(DEPTH - 1))) w_next = S_DRAIN;
        else if (!in_valid && (r_count != CNT_W'(0)))  w_next = S_DRAIN;
        else                                           w_next = S_COLLECT;
      end
      S_DRAIN: begin
        if (w_last) w_next = S_IDLE;
        else        w_next = S_DRAIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err_total <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_last) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Accept and pop are mutually exclusive: accept needs state != DRAIN.
      if (w_accept)   r_count <= r_count + CNT_W'(1);
      else if (w_pop) r_count <= r_count - CNT_W'(1);
      if (w_accept && (w_dec[1] || w_dec[0]) && (r_err_total != 4'd15))
        r_err_total <= r_err_total + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_ptr] <= w_dec;
  end

  assign w_head      = r_buf[r_rd_ptr];
  assign out_valid   = (r_state == S_DRAIN);
  assign out_data    = out_valid ? w_head[9:2] : 8'h00;
  assign out_err_fix = out_valid ? w_head[1]   : 1'b0;
  assign out_err_bad = out_valid ? w_head[0]   : 1'b0;
  assign state       = r_state;
  assign count       = r_count;
  assign err_total   = r_err_total;

endmodule
